// File: rtl/alu_unit.sv
// Integer/branch execution unit. It computes one op per cycle into a small result FIFO.
// The FIFO drains onto the CDB under arbiter grant and also carries branch/jump resolution.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ROB_W  = 4;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } alu_op_e;
endpackage

module alu_unit
  import alu_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              rs_to_alu_ready,
  input  alu_op_e           rs_to_alu_op,
  input  logic [DATA_W-1:0] rs_to_alu_rs1,
  input  logic [DATA_W-1:0] rs_to_alu_rs2,
  input  logic [ROB_W-1:0]  rs_to_alu_rob_index,
  input  logic [ADDR_W-1:0] rs_to_alu_PC,
  input  logic [DATA_W-1:0] rs_to_alu_imm,
  input  logic              cdb_grant,
  output logic              alu_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [ROB_W-1:0]  alu_rob_index,
  output logic              alu_jump,
  output logic [ADDR_W-1:0] alu_target_PC,
  output logic              alu_stall,
  output logic              alu_overflow
);
  localparam int ENT_W = DATA_W + ROB_W + 1 + ADDR_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QUEUE_DEPTH);

  logic [DATA_W-1:0] op_b, c_result;
  logic [ADDR_W-1:0] pc_plus4, c_target, jalr_sum;
  logic              c_jump, is_imm, is_branch, br_taken;
  logic [ENT_W-1:0]  c_entry;

  always_comb begin
    is_imm    = rs_to_alu_op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                                     OP_SLLI, OP_SRLI, OP_SRAI, OP_JALR};
    is_branch = rs_to_alu_op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    op_b      = is_imm ? rs_to_alu_imm : rs_to_alu_rs2;
    pc_plus4  = rs_to_alu_PC + 32'd4;
    jalr_sum  = rs_to_alu_rs1 + rs_to_alu_imm;
    c_result  = '0;
    c_target  = pc_plus4;
    c_jump    = 1'b0;
    br_taken  = 1'b0;
    case (rs_to_alu_op)
      OP_ADD, OP_ADDI:   c_result = rs_to_alu_rs1 + op_b;
      OP_SUB:            c_result = rs_to_alu_rs1 - op_b;
      OP_AND, OP_ANDI:   c_result = rs_to_alu_rs1 & op_b;
      OP_OR, OP_ORI:     c_result = rs_to_alu_rs1 | op_b;
      OP_XOR, OP_XORI:   c_result = rs_to_alu_rs1 ^ op_b;
      OP_SLL, OP_SLLI:   c_result = rs_to_alu_rs1 << op_b[4:0];
      OP_SRL, OP_SRLI:   c_result = rs_to_alu_rs1 >> op_b[4:0];
      OP_SRA, OP_SRAI:   c_result = $signed(rs_to_alu_rs1) >>> op_b[4:0];
      OP_SLT, OP_SLTI:   c_result = {{(DATA_W-1){1'b0}}, $signed(rs_to_alu_rs1) < $signed(op_b)};
      OP_SLTU, OP_SLTIU: c_result = {{(DATA_W-1){1'b0}}, rs_to_alu_rs1 < op_b};
      OP_LUI:            c_result = rs_to_alu_imm;
      OP_AUIPC:          c_result = rs_to_alu_PC + rs_to_alu_imm;
      OP_JAL: begin
        c_result = pc_plus4;
        c_target = rs_to_alu_PC + rs_to_alu_imm;
        c_jump   = 1'b1;
      end
      OP_JALR: begin
        c_result = pc_plus4;
        c_target = {jalr_sum[ADDR_W-1:1], 1'b0};
        c_jump   = ({jalr_sum[ADDR_W-1:1], 1'b0} != pc_plus4);
      end
      OP_BEQ:  br_taken = (rs_to_alu_rs1 == rs_to_alu_rs2);
      OP_BNE:  br_taken = (rs_to_alu_rs1 != rs_to_alu_rs2);
      OP_BLT:  br_taken = ($signed(rs_to_alu_rs1) < $signed(rs_to_alu_rs2));
      OP_BGE:  br_taken = ($signed(rs_to_alu_rs1) >= $signed(rs_to_alu_rs2));
      OP_BLTU: br_taken = (rs_to_alu_rs1 < rs_to_alu_rs2);
      OP_BGEU: br_taken = (rs_to_alu_rs1 >= rs_to_alu_rs2);
      default: c_result = '0;
    endcase
    if (is_branch) begin
      c_jump   = br_taken;
      c_target = br_taken ? (rs_to_alu_PC + rs_to_alu_imm) : pc_plus4;
    end
    c_entry = {c_result, rs_to_alu_rob_index, c_jump, c_target};
  end

  // Handshake: rs_to_alu_ready is a valid strobe, taken on an edge with rdy_in && !clr_in when a
  // slot is free or the head leaves that same edge; the head leaves on an edge where
  // alu_ready && cdb_grant (with rdy_in && !clr_in). alu_stall is the only backpressure to dispatch.
  logic [ENT_W-1:0] fifo_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_next;
  logic             stall_q, ovf_q;
  logic             push, pop, drop;

  always_comb begin
    pop  = rdy_in && !clr_in && (count_q != '0) && cdb_grant;
    push = rdy_in && !clr_in && rs_to_alu_ready && ((count_q < DEPTH_C) || pop);
    drop = rdy_in && !clr_in && rs_to_alu_ready && (count_q == DEPTH_C) && !pop;
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
    end else if (clr_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else if (rdy_in) begin
      if (push) begin
        fifo_q[tail_q] <= c_entry;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_next;
      // Stall one entry early: dispatch is registered, so one more op may already be in flight.
      stall_q <= (count_next >= (DEPTH_C - 1'b1));
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign {alu_result, alu_rob_index, alu_jump, alu_target_PC} = fifo_q[head_q];
  assign alu_ready    = (count_q != '0);
  assign alu_stall    = stall_q;
  assign alu_overflow = ovf_q;
endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed scenarios plus random traffic, scored against an
// arithmetic reference model with an expected-result queue.
module tb_alu_unit;
  import alu_pkg::*;

  localparam int EXP_W = 32 + 4 + 1 + 32;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, rs_to_alu_ready, cdb_grant;
  alu_op_e     rs_to_alu_op;
  logic [31:0] rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_PC, rs_to_alu_imm;
  logic [3:0]  rs_to_alu_rob_index;
  logic        alu_ready, alu_jump, alu_stall, alu_overflow;
  logic [31:0] alu_result, alu_target_PC;
  logic [3:0]  alu_rob_index;

  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic             ovf_m = 1'b0;

  alu_unit #(.QUEUE_DEPTH(4), .PTR_W(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
    .rs_to_alu_rs1(rs_to_alu_rs1), .rs_to_alu_rs2(rs_to_alu_rs2),
    .rs_to_alu_rob_index(rs_to_alu_rob_index), .rs_to_alu_PC(rs_to_alu_PC),
    .rs_to_alu_imm(rs_to_alu_imm), .cdb_grant(cdb_grant),
    .alu_ready(alu_ready), .alu_result(alu_result), .alu_rob_index(alu_rob_index),
    .alu_jump(alu_jump), .alu_target_PC(alu_target_PC), .alu_stall(alu_stall),
    .alu_overflow(alu_overflow)
  );

  // ---------------- clock/reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {rd value, jump, next PC}
  function automatic logic [64:0] ref_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] r2, input logic [31:0] im,
                                           input logic [31:0] pc_v);
    logic [31:0] res, tgt, b, ones;
    logic        jmp, taken, is_br;
    int          sh;
    ones  = 32'hFFFFFFFF;
    res   = 32'h0;
    tgt   = pc_v + 32'd4;
    jmp   = 1'b0;
    taken = 1'b0;
    is_br = 1'b0;
    b     = (op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                        OP_SLLI, OP_SRLI, OP_SRAI, OP_JALR}) ? im : r2;
    sh    = int'(b % 32);
    case (op)
      OP_ADD, OP_ADDI:   res = a + b;
      OP_SUB:            res = a - b;
      OP_AND, OP_ANDI:   res = a & b;
      OP_OR, OP_ORI:     res = a | b;
      OP_XOR, OP_XORI:   res = a ^ b;
      OP_SLL, OP_SLLI:   res = a << sh;
      OP_SRL, OP_SRLI:   res = a >> sh;
      OP_SRA, OP_SRAI:   res = (a >> sh) | ((a >= 32'h80000000) ? ~(ones >> sh) : 32'h0);
      OP_SLT, OP_SLTI:   res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      OP_LUI:            res = im;
      OP_AUIPC:          res = pc_v + im;
      OP_JAL:  begin res = pc_v + 32'd4; tgt = pc_v + im; jmp = 1'b1; end
      OP_JALR: begin
        res = pc_v + 32'd4;
        tgt = (a + im) & 32'hFFFFFFFE;
        jmp = (tgt != pc_v + 32'd4);
      end
      OP_BEQ:  begin is_br = 1'b1; taken = (a == r2); end
      OP_BNE:  begin is_br = 1'b1; taken = (a != r2); end
      OP_BLT:  begin is_br = 1'b1; taken = (int'(a) < int'(r2)); end
      OP_BGE:  begin is_br = 1'b1; taken = (int'(a) >= int'(r2)); end
      OP_BLTU: begin is_br = 1'b1; taken = (longint'(a) < longint'(r2)); end
      OP_BGEU: begin is_br = 1'b1; taken = (longint'(a) >= longint'(r2)); end
      default: res = 32'h0;
    endcase
    if (is_br) begin
      jmp = taken;
      tgt = taken ? pc_v + im : pc_v + 32'd4;
      res = 32'h0;
    end
    return {res, jmp, tgt};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int               sz_m;
  logic             pop_m;
  logic [64:0]      rc_m;
  logic [EXP_W-1:0] e_m;

  initial forever begin
    @(posedge rst_in);
    exp_q.delete();
    ovf_m = 1'b0;
  end

  initial forever begin
    @(negedge clk_in);
    if (!rst_in) begin
      sz_m = exp_q.size();
      chk("ready", {63'b0, alu_ready}, {63'b0, sz_m != 0});
      chk("stall", {63'b0, alu_stall}, {63'b0, sz_m >= 3});
      chk("overflow", {63'b0, alu_overflow}, {63'b0, ovf_m});
      if (sz_m != 0) begin
        e_m = exp_q[0];
        chk("head_result", {32'b0, alu_result}, {32'b0, e_m[68:37]});
        chk("head_rob", {60'b0, alu_rob_index}, {60'b0, e_m[36:33]});
        chk("head_jump", {63'b0, alu_jump}, {63'b0, e_m[32]});
        chk("head_target", {32'b0, alu_target_PC}, {32'b0, e_m[31:0]});
      end
      pop_m = rdy_in && !clr_in && (sz_m != 0) && cdb_grant;
      if (pop_m) void'(exp_q.pop_front());
      if (rdy_in && !clr_in && rs_to_alu_ready) begin
        if (sz_m < 4 || pop_m) begin
          rc_m = ref_calc(rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC);
          exp_q.push_back({rc_m[64:33], rs_to_alu_rob_index, rc_m[32], rc_m[31:0]});
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (clr_in) exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] pc_v, input logic [3:0] t);
    rs_to_alu_ready     = 1'b1;
    rs_to_alu_op        = op;
    rs_to_alu_rs1       = a;
    rs_to_alu_rs2       = b;
    rs_to_alu_imm       = im;
    rs_to_alu_PC        = pc_v;
    rs_to_alu_rob_index = t;
  endtask

  task automatic drive_rand(input logic [3:0] t);
    logic [31:0] a, b, im;
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    im = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
    drive(alu_op_e'(5'($urandom_range(0, 28))), a, b, im, $urandom & 32'hFFFFFFFC, t);
  endtask

  // One dispatch, then park at the following negedge so the caller can inspect the head.
  task automatic issue1(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] pc_v, input logic [3:0] t);
    drive(op, a, b, im, pc_v, t);
    cdb_grant = 1'b1;
    step();
    rs_to_alu_ready = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic drain(input string name);
    rs_to_alu_ready = 1'b0;
    clr_in          = 1'b0;
    rdy_in          = 1'b1;
    cdb_grant       = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk(name, 64'(exp_q.size()), 64'd0);
    cdb_grant = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; cdb_grant = 1'b0;
    drive(OP_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1);
    rs_to_alu_ready = 1'b0;
    #1 rst_in = 1'b1;
    repeat (2) step();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_ready", {63'b0, alu_ready}, 64'd0);
    chk("rst_stall", {63'b0, alu_stall}, 64'd0);
    chk("rst_overflow", {63'b0, alu_overflow}, 64'd0);
    chk("rst_result", {32'b0, alu_result}, 64'd0);
    step();

    // T1: ADDI with negative immediate
    issue1(OP_ADDI, 32'd5, 32'd99, 32'hFFFFFFF9, 32'h0, 4'd3);
    chk("t1_ready", {63'b0, alu_ready}, 64'd1);
    chk("t1_result", {32'b0, alu_result}, 64'hFFFFFFFE);
    chk("t1_rob", {60'b0, alu_rob_index}, 64'd3);
    chk("t1_jump", {63'b0, alu_jump}, 64'd0);
    step();

    // T2: signed vs unsigned branch on the same operands
    issue1(OP_BLT, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd4);
    chk("t2_blt_jump", {63'b0, alu_jump}, 64'd1);
    chk("t2_blt_target", {32'b0, alu_target_PC}, 64'h120);
    step();
    issue1(OP_BLTU, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd5);
    chk("t2_bltu_jump", {63'b0, alu_jump}, 64'd0);
    chk("t2_bltu_target", {32'b0, alu_target_PC}, 64'h104);
    step();

    // T3: JALR clears target bit 0
    issue1(OP_JALR, 32'h1001, 32'd7, 32'd4, 32'h40, 4'd6);
    chk("t3_result", {32'b0, alu_result}, 64'h44);
    chk("t3_target", {32'b0, alu_target_PC}, 64'h1004);
    chk("t3_jump", {63'b0, alu_jump}, 64'd1);
    step();

    // T4: three queued without grant, then drained in order
    cdb_grant = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive_rand(4'(t));
      step();
    end
    rs_to_alu_ready = 1'b0;
    @(negedge clk_in);
    chk("t4_stall", {63'b0, alu_stall}, 64'd1);
    step();
    cdb_grant = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      chk("t4_order", {60'b0, alu_rob_index}, 64'(k));
      step();
    end
    cdb_grant = 1'b0;
    @(negedge clk_in);
    chk("t4_empty", {63'b0, alu_ready}, 64'd0);
    step();

    // T5: overflow on full FIFO, then push+pop while full
    for (int t = 1; t <= 5; t++) begin
      drive_rand(4'(t));
      step();
    end
    rs_to_alu_ready = 1'b0;
    @(negedge clk_in);
    chk("t5_overflow", {63'b0, alu_overflow}, 64'd1);
    chk("t5_head", {60'b0, alu_rob_index}, 64'd1);
    step();
    drive_rand(4'd6);
    cdb_grant = 1'b1;
    step();
    rs_to_alu_ready = 1'b0;
    cdb_grant       = 1'b0;
    @(negedge clk_in);
    chk("t5_full_stall", {63'b0, alu_stall}, 64'd1);
    chk("t5_head2", {60'b0, alu_rob_index}, 64'd2);
    step();
    drain("t5_drain");

    // T6: flush with simultaneous dispatch and grant
    for (int t = 1; t <= 2; t++) begin
      drive_rand(4'(t));
      step();
    end
    drive_rand(4'd9);
    clr_in    = 1'b1;
    cdb_grant = 1'b1;
    step();
    clr_in = 1'b0; cdb_grant = 1'b0; rs_to_alu_ready = 1'b0;
    @(negedge clk_in);
    chk("t6_clr_ready", {63'b0, alu_ready}, 64'd0);
    chk("t6_clr_stall", {63'b0, alu_stall}, 64'd0);
    chk("t6_clr_ovf_kept", {63'b0, alu_overflow}, 64'd1);
    step();

    // T6: asynchronous reset in the middle of a drain
    for (int t = 1; t <= 3; t++) begin
      drive_rand(4'(t + 10));
      step();
    end
    rs_to_alu_ready = 1'b0;
    cdb_grant       = 1'b1;
    step();
    #2 rst_in = 1'b1;
    #1;
    chk("t6_rst_ready", {63'b0, alu_ready}, 64'd0);
    chk("t6_rst_result", {32'b0, alu_result}, 64'd0);
    chk("t6_rst_rob", {60'b0, alu_rob_index}, 64'd0);
    chk("t6_rst_target", {32'b0, alu_target_PC}, 64'd0);
    chk("t6_rst_stall", {63'b0, alu_stall}, 64'd0);
    chk("t6_rst_overflow", {63'b0, alu_overflow}, 64'd0);
    cdb_grant = 1'b0;
    step();
    rst_in = 1'b0;
    step();

    // Random traffic with holds, flushes and occasional over-dispatch
    for (int c = 0; c < 600; c++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      clr_in    = ($urandom_range(0, 59) == 0);
      cdb_grant = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1 && (!alu_stall || $urandom_range(0, 9) == 0))
        drive_rand(4'($urandom_range(1, 15)));
      else
        rs_to_alu_ready = 1'b0;
      step();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
